// File: rtl/lp805x_prescaler.sv
// -----------------------------------------------------------------------------
// lp805x_prescaler
//
// Purpose:
//   Turns the 3-bit prescaler index from the frequency-select scheduler into a
//   periodic, single-cycle clock-enable tick. The divide ratio is 2^index, so
//   the tick period runs from 1 to 128 clk cycles.
//
//   By default, a new index is staged and applied only on a tick boundary.
//   Downstream timers and the UART therefore never see a shortened or
//   stretched period.
//
// Configuration macro:
//   LP805X_PRESC_IMMEDIATE_EN
//     Defined: a load while running takes effect at once. The period counter
//     restarts and the current period is abandoned. The pending output is
//     tied to 0.
//     Undefined (default): loads made while running are staged until the
//     next boundary.
//
// Parameters:
//   CNT_W     : period counter width. Must be >= 7 so that a ratio of 128 fits.
//   RST_INDEX : index loaded into the current and staged index on reset.
//
// Ports:
//   clk       in   system clock, all logic on the rising edge
//   rst       in   asynchronous active-high reset
//   index     in   [2:0] requested prescaler index
//   load      in   single-cycle strobe that samples index
//   enable    in   level; 1 = generate ticks, 0 = idle
//   tick      out  registered, one clk wide, once per 2^cur_index cycles
//   run       out  registered, 1 while running
//   pending   out  registered, 1 while a loaded index awaits a boundary
//   cur_index out  [2:0] registered index currently governing the period
// -----------------------------------------------------------------------------
module lp805x_prescaler #(
  parameter int         CNT_W     = 7,
  parameter logic [2:0] RST_INDEX = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] index,
  input  logic       load,
  input  logic       enable,
  output logic       tick,
  output logic       run,
  output logic       pending,
  output logic [2:0] cur_index
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cur_q, cur_d;
  logic [2:0]       pend_q, pend_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;

  // Terminal count of the current period: 2^cur - 1.
  // Only the low bits can be set, so the value always fits in CNT_W >= 7.
  logic [CNT_W-1:0] last;
  assign last = (CNT_W'(1) << cur_q) - CNT_W'(1);

  logic at_boundary;
  assign at_boundary = (cnt_q == last);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    tick_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // While idle there is no period in flight, so a load applies directly.
        // A simultaneous enable then starts the run with the new ratio.
        if (load) begin
          cur_d = index;
        end
        if (enable) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          // Flush any staged index so that the next run starts with it.
          if (pending_q) begin
            cur_d     = pend_q;
            pending_d = 1'b0;
          end
`ifdef LP805X_PRESC_IMMEDIATE_EN
        end else if (load) begin
          // Abandon the current period and count the new ratio from this edge.
          cur_d = index;
          cnt_d = '0;
`endif
        end else if (at_boundary) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          // A load on the boundary edge itself beats the staged value.
          if (load) begin
            cur_d     = index;
            pending_d = 1'b0;
          end else if (pending_q) begin
            cur_d     = pend_q;
            pending_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Back-to-back loads overwrite the staging register: the last one wins.
          if (load) begin
            pend_d    = index;
            pending_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cur_q     <= RST_INDEX;
      pend_q    <= RST_INDEX;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
    end
  end

  assign tick      = tick_q;
  assign run       = (state_q == ST_RUN);
  assign cur_index = cur_q;
`ifdef LP805X_PRESC_IMMEDIATE_EN
  assign pending   = 1'b0;
`else
  assign pending   = pending_q;
`endif

endmodule

// File: tb/tb_lp805x_prescaler.sv
// -----------------------------------------------------------------------------
// Testbench for lp805x_prescaler.
//
// The reference model does not count cycles within a period. Instead it
// records the absolute edge number at which the next tick is due. Loaded
// indices are held in a queue, and a boundary takes the newest entry.
// -----------------------------------------------------------------------------
module tb_lp805x_prescaler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] index = 3'd0;
  logic       load = 1'b0;
  logic       enable = 1'b0;
  logic       tick;
  logic       run;
  logic       pending;
  logic [2:0] cur_index;

  always #5 clk = ~clk;

  lp805x_prescaler #(.CNT_W(7), .RST_INDEX(3'd0)) dut (
    .clk       (clk),
    .rst       (rst),
    .index     (index),
    .load      (load),
    .enable    (enable),
    .tick      (tick),
    .run       (run),
    .pending   (pending),
    .cur_index (cur_index)
  );

  int passed = 0;
  int total  = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit m_run;
  bit m_tick;
  int m_cur;
  int m_edge = 0;
  int m_next;   // edge number at which the next tick is due
  int staged[$];

  function automatic void model_reset();
    m_run  = 1'b0;
    m_tick = 1'b0;
    m_cur  = 0;
    staged.delete();
  endfunction

  function automatic void model_edge();
    m_edge++;
    if (rst) begin
      model_reset();
    end else if (!m_run) begin
      m_tick = 1'b0;
      if (load) m_cur = int'(index);
      if (enable) begin
        m_run  = 1'b1;
        m_next = m_edge + (1 << m_cur);
      end
    end else if (!enable) begin
      m_run  = 1'b0;
      m_tick = 1'b0;
      if (staged.size() != 0) m_cur = staged[$];
      staged.delete();
`ifdef LP805X_PRESC_IMMEDIATE_EN
    end else if (load) begin
      m_tick = 1'b0;
      m_cur  = int'(index);
      m_next = m_edge + (1 << m_cur);
`endif
    end else if (m_edge == m_next) begin
      m_tick = 1'b1;
      if (load) m_cur = int'(index);
      else if (staged.size() != 0) m_cur = staged[$];
      staged.delete();
      m_next = m_edge + (1 << m_cur);
    end else begin
      m_tick = 1'b0;
      if (load) staged.push_back(int'(index));
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, m_edge, obs, exp);
  endtask

  task automatic check_all();
    chk("tick", {31'd0, tick}, {31'd0, m_tick});
    chk("run", {31'd0, run}, {31'd0, m_run});
    chk("pending", {31'd0, pending}, (staged.size() != 0) ? 32'd1 : 32'd0);
    chk("cur_index", {29'd0, cur_index}, 32'(m_cur));
  endtask

  // One clock edge: update the model with the inputs present at the edge,
  // then sample the DUT 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [2:0] idx);
    index = idx;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  // Advance until the model's next tick. The wait is bounded, and running out
  // of budget counts as a failed comparison.
  task automatic wait_tick(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (m_tick) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wait_tick_timeout", {31'd0, seen}, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    model_reset();
    #1;
    check_all();
    cycles(2);
    rst = 1'b0;
    cycles(2);

    // 1: index 0 loaded together with enable -> tick every cycle
    index  = 3'd0;
    load   = 1'b1;
    enable = 1'b1;
    step();
    load = 1'b0;
    cycles(6);

    // 2: idle, load 3, enable -> 8-cycle period, 10 periods
    enable = 1'b0;
    step();
    do_load(3'd3);
    enable = 1'b1;
    cycles(82);

    // 3: mid-period load of 1 (counter == 2) -> staged until boundary
    wait_tick(20);
    cycles(2);
    do_load(3'd1);
    cycles(20);

    // 4: reach index 2, then load 5 exactly on a boundary edge
    do_load(3'd2);
    wait_tick(20);
    wait_tick(20);
    cycles(3);
    do_load(3'd5);
    cycles(70);

    // 5: load 7 mid-period, drop enable before boundary, re-enable
    cycles(4);
    do_load(3'd7);
    cycles(3);
    enable = 1'b0;
    step();
    cycles(3);
    enable = 1'b1;
    cycles(300);

    // 6: asynchronous reset mid-period at index 4 with a pending index
    enable = 1'b0;
    step();
    do_load(3'd4);
    enable = 1'b1;
    cycles(10);
    do_load(3'd2);
    step();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    cycles(3);
    rst = 1'b0;
    cycles(2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      index  = 3'($urandom_range(0, 7));
      load   = ($urandom_range(0, 9) == 0);
      enable = ($urandom_range(0, 60) != 0);
      rst    = ($urandom_range(0, 400) == 0);
      step();
      rst  = 1'b0;
      load = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
